// File: rtl/data_mem_bank_pkg.sv
// Shared types and helpers for the data memory bank.
// Optional parity storage: DATA_MEM_BANK_PARITY_EN.
package data_mem_bank_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } st_t;

  localparam int LANE_BITS = 8;

  function automatic logic even_par(
    input logic [7:0] b
  );
    return ^b;
  endfunction

  function automatic int idx_w(
    input int depth
  );
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/data_mem_bank_if.sv
// Request/response bus of the data memory bank.
// CPU side is master, memory side is slave.
interface data_mem_bank_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int BE_W   = DATA_W / 8
);

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_perr;

  modport master (
    output req_valid,
    output req_wr,
    output req_addr,
    output req_wdata,
    output req_be,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err,
    input  rsp_perr
  );

  modport slave (
    input  req_valid,
    input  req_wr,
    input  req_addr,
    input  req_wdata,
    input  req_be,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err,
    output rsp_perr
  );

endinterface

// File: rtl/data_mem_array.sv
// Storage array: per-lane write enables,
// registered synchronous read, no reset.
module data_mem_array #(
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8,
  parameter int LANES  = 1,
  parameter int LANE_W = 8,
  localparam int WORD_W = LANES * LANE_W
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  addr,
  input  logic [LANES-1:0]  we,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Lane-masked write and registered read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) begin
        mem[addr][i*LANE_W +: LANE_W] <=
          wdata[i*LANE_W +: LANE_W];
      end
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_bank.sv
// Data memory bank: clear engine, handshakes,
// range check. Option: DATA_MEM_BANK_PARITY_EN.
module data_mem_bank
  import data_mem_bank_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_req,
  output logic clr_busy,
  data_mem_bank_if.slave bus
);

  localparam int IDX_W = idx_w(DEPTH);
`ifdef DATA_MEM_BANK_PARITY_EN
  localparam int LANE_W = LANE_BITS + 1;
`else
  localparam int LANE_W = LANE_BITS;
`endif
  localparam int WORD_W = LANE_W * BE_W;
  localparam int DEPTH_M1 = DEPTH - 1;
  localparam logic [ADDR_W:0] DEPTH_X =
    DEPTH[ADDR_W:0];
  localparam logic [IDX_W-1:0] LAST =
    DEPTH_M1[IDX_W-1:0];

  st_t              state;
  st_t              state_n;
  logic [IDX_W-1:0] clr_addr;
  logic [IDX_W-1:0] clr_addr_n;

  logic             in_range;
  logic             acc;
  logic             rd_acc;
  logic             wr_acc;
  logic [IDX_W-1:0] idx;

  logic [BE_W-1:0]   arr_we;
  logic              arr_re;
  logic [IDX_W-1:0]  arr_addr;
  logic [WORD_W-1:0] arr_wdata;
  logic [WORD_W-1:0] arr_rdata;
  logic [WORD_W-1:0] req_word;
  logic [DATA_W-1:0] rd_data;

  logic rsp_valid_q;
  logic rsp_err_q;

  assign in_range = {1'b0, bus.req_addr} < DEPTH_X;
  assign idx      = bus.req_addr[IDX_W-1:0];
  assign clr_busy = (state == ST_CLEAR);

  assign bus.req_ready = (state == ST_IDLE)
                      && !clr_req
                      && (!rsp_valid_q || bus.rsp_ready);

  assign acc    = bus.req_valid && bus.req_ready;
  assign rd_acc = acc && !bus.req_wr;
  assign wr_acc = acc && bus.req_wr;

  // State and clear address registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_n;
      clr_addr <= clr_addr_n;
    end
  end

  // Clear sweep one word per cycle; clr_req only in IDLE.
  always_comb begin
    state_n    = state;
    clr_addr_n = clr_addr;
    unique case (state)
      ST_CLEAR: begin
        if (clr_addr == LAST) begin
          state_n    = ST_IDLE;
          clr_addr_n = '0;
        end else begin
          clr_addr_n = clr_addr + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          state_n    = ST_CLEAR;
          clr_addr_n = '0;
        end
      end
    endcase
  end

  // Pack request data into lanes, with parity if stored.
  always_comb begin
    req_word = '0;
    for (int i = 0; i < BE_W; i++) begin
      req_word[i*LANE_W +: 8] =
        bus.req_wdata[i*8 +: 8];
`ifdef DATA_MEM_BANK_PARITY_EN
      req_word[i*LANE_W + 8] =
        even_par(bus.req_wdata[i*8 +: 8]);
`endif
    end
  end

  // Array port: clear sweep, in-range write, or read.
  always_comb begin
    arr_we    = '0;
    arr_re    = 1'b0;
    arr_addr  = idx;
    arr_wdata = req_word;
    unique case (1'b1)
      clr_busy: begin
        arr_we    = '1;
        arr_wdata = '0;
        arr_addr  = clr_addr;
      end
      wr_acc: arr_we = in_range ? bus.req_be : '0;
      rd_acc: arr_re = in_range;
      default: ;
    endcase
  end

  data_mem_array #(
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .LANES  (BE_W),
    .LANE_W (LANE_W)
  ) u_arr (
    .clk   (clk),
    .addr  (arr_addr),
    .we    (arr_we),
    .wdata (arr_wdata),
    .re    (arr_re),
    .rdata (arr_rdata)
  );

  // Response flags; held until the consumer takes them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else if (rd_acc) begin
      rsp_valid_q <= 1'b1;
      rsp_err_q   <= !in_range;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  // Strip parity bits from the stored word.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < BE_W; i++) begin
      rd_data[i*8 +: 8] = arr_rdata[i*LANE_W +: 8];
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata =
    (rsp_valid_q && !rsp_err_q) ? rd_data : '0;

`ifdef DATA_MEM_BANK_PARITY_EN
  logic perr;

  // Any lane whose stored parity disagrees flags an error.
  always_comb begin
    perr = 1'b0;
    for (int i = 0; i < BE_W; i++) begin
      if (arr_rdata[i*LANE_W + 8] !=
          even_par(arr_rdata[i*LANE_W +: 8])) begin
        perr = 1'b1;
      end
    end
  end

  assign bus.rsp_perr =
    rsp_valid_q && !rsp_err_q && perr;
`else
  assign bus.rsp_perr = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_bank.sv
// Scoreboard bench for data_mem_bank
// (DATA_W=32, DEPTH=200).
module tb_data_mem_bank;

  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int DEP = 200;
  localparam int BW  = DW / 8;

  typedef struct {
    logic [DW-1:0] d;
    logic          e;
    logic          p;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_req = 1'b0;
  logic clr_busy;

  logic rand_bp = 1'b0;
  logic man_ready = 1'b1;
  logic bp_bit = 1'b1;

  int total = 0;
  int bad = 0;

  exp_t sb[$];
  logic [DW-1:0] model [256];

  logic          hold_p = 1'b0;
  logic [DW-1:0] hold_d;
  logic          hold_e;

  data_mem_bank_if #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) bus ();

  data_mem_bank #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DEPTH  (DEP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  assign bus.rsp_ready = rand_bp ? bp_bit : man_ready;

  always @(posedge clk) begin
    #1;
    bp_bit <= ($urandom_range(0, 3) != 0);
  end

  task automatic chk(
    input string      n,
    input logic [63:0] a,
    input logic [63:0] e
  );
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  // Reference: words addressed directly, out of range never stored.
  task automatic note(
    input bit            wr,
    input logic [AW-1:0] a,
    input logic [DW-1:0] d,
    input logic [BW-1:0] be,
    input bit            pexp
  );
    exp_t x;
    if (wr) begin
      if (int'(a) < DEP) begin
        for (int i = 0; i < BW; i++) begin
          if (be[i]) model[a][i*8 +: 8] = d[i*8 +: 8];
        end
      end
    end else begin
      x.e = !(int'(a) < DEP);
      x.d = x.e ? '0 : model[a];
      x.p = pexp;
      sb.push_back(x);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(
    input bit            wr,
    input logic [AW-1:0] a,
    input logic [DW-1:0] d,
    input logic [BW-1:0] be,
    input bit            pexp
  );
    bit done;
    done = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_be    = be;
    for (int k = 0; k < 500 && !done; k++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        note(wr, a, d, be, pexp);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: addr %0h got no ready want ready", a);
    end
  endtask

  task automatic count_clear(
    input  int pulse_at,
    output int n,
    output int rdy
  );
    n = 0;
    rdy = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (!clr_busy) break;
      n++;
      if (bus.req_ready) rdy++;
      clr_req = (n == pulse_at);
    end
    clr_req = 1'b0;
  endtask

  // Monitor: pop expected response on every handshake.
  always @(negedge clk) begin
    exp_t x;
    if (hold_p) begin
      chk("hold_valid", 64'(bus.rsp_valid), 64'(1));
      chk("hold_data", 64'(bus.rsp_rdata), 64'(hold_d));
      chk("hold_err", 64'(bus.rsp_err), 64'(hold_e));
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got %0h want none", bus.rsp_rdata);
      end else begin
        x = sb.pop_front();
        chk("rsp_data", 64'(bus.rsp_rdata), 64'(x.d));
        chk("rsp_err", 64'(bus.rsp_err), 64'(x.e));
        chk("rsp_perr", 64'(bus.rsp_perr), 64'(x.p));
      end
    end
    hold_p <= bus.rsp_valid && !bus.rsp_ready;
    hold_d <= bus.rsp_rdata;
    hold_e <= bus.rsp_err;
  end

  initial begin
    int n;
    int rdy;
    logic [AW-1:0] a;
    for (int i = 0; i < 256; i++) model[i] = '0;
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_rdata", 64'(bus.rsp_rdata), 64'(0));
    chk("rst_err", 64'(bus.rsp_err), 64'(0));
    chk("rst_perr", 64'(bus.rsp_perr), 64'(0));
    chk("rst_ready", 64'(bus.req_ready), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Clear after reset, request held pending
    count_clear(0, n, rdy);
    chk("clr_cycles", 64'(n), 64'(DEP));
    chk("clr_ready_low", 64'(rdy), 64'(0));
    chk("clr_done_ready", 64'(bus.req_ready), 64'(1));
    note(1'b0, '0, '0, '0, 1'b0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 256; i++) begin
      issue(1'b0, AW'(i), '0, '0, 1'b0);
    end

    // Write then read next cycle
    issue(1'b1, 8'h10, 32'hA5, 4'hF, 1'b0);
    issue(1'b0, 8'h10, '0, '0, 1'b0);
    chk("rd_latency", 64'(bus.rsp_valid), 64'(1));
    chk("rd_a5", 64'(bus.rsp_rdata), 64'h0000_00A5);

    // Byte-lane merge
    issue(1'b1, 8'h20, 32'h1122_3344, 4'hF, 1'b0);
    issue(1'b1, 8'h20, 32'hFFFF_FFFF, 4'h5, 1'b0);
    issue(1'b0, 8'h20, '0, '0, 1'b0);
    chk("be_merge", 64'(bus.rsp_rdata), 64'h11FF_33FF);

    // Range boundary
    issue(1'b1, 8'hC8, 32'h5A, 4'hF, 1'b0);
    issue(1'b0, 8'hC8, '0, '0, 1'b0);
    chk("oor_err", 64'(bus.rsp_err), 64'(1));
    chk("oor_data", 64'(bus.rsp_rdata), 64'(0));
    issue(1'b0, 8'hC7, '0, '0, 1'b0);
    chk("last_err", 64'(bus.rsp_err), 64'(0));

    // Response backpressure
    issue(1'b1, 8'h01, 32'hDEAD_BEEF, 4'hF, 1'b0);
    issue(1'b1, 8'h02, 32'h0BAD_F00D, 4'hF, 1'b0);
    idle(2);
    man_ready = 1'b0;
    issue(1'b0, 8'h01, '0, '0, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 8'h02;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready", 64'(bus.req_ready), 64'(0));
      chk("stall_valid", 64'(bus.rsp_valid), 64'(1));
      chk("stall_data", 64'(bus.rsp_rdata), 64'hDEAD_BEEF);
    end
    @(posedge clk);
    #1;
    man_ready = 1'b1;
    issue(1'b0, 8'h02, '0, '0, 1'b0);
    idle(2);

    // clr_req beats request; reset mid-clear restarts
    issue(1'b1, 8'h03, 32'h1234_5678, 4'hF, 1'b0);
    idle(2);
    clr_req       = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_addr  = 8'h03;
    bus.req_wdata = 32'h77;
    bus.req_be    = 4'hF;
    @(negedge clk);
    chk("clr_beats_req", 64'(bus.req_ready), 64'(0));
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = '0;
    @(negedge clk);
    chk("clr_started", 64'(clr_busy), 64'(1));
    @(posedge clk);
    #1;
    idle(99);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    count_clear(50, n, rdy);
    chk("reclr_cycles", 64'(n), 64'(DEP));
    chk("reclr_ready_low", 64'(rdy), 64'(0));
    @(posedge clk);
    #1;
    issue(1'b0, 8'h03, '0, '0, 1'b0);
    issue(1'b0, 8'h10, '0, '0, 1'b0);
    issue(1'b0, 8'h20, '0, '0, 1'b0);

`ifdef DATA_MEM_BANK_PARITY_EN
    issue(1'b1, 8'h30, 32'hCAFE_F00D, 4'hF, 1'b0);
    idle(2);
    dut.u_arr.mem[8'h30][8] = ~dut.u_arr.mem[8'h30][8];
    issue(1'b0, 8'h30, '0, '0, 1'b1);
    idle(2);
`endif

    // Randomized traffic with random backpressure
    rand_bp = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = AW'($urandom_range(0, 255));
      end else begin
        a = AW'($urandom_range(0, 15));
      end
      issue(1'($urandom_range(0, 1)), a,
            DW'($urandom), BW'($urandom_range(0, 15)),
            1'b0);
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    rand_bp = 1'b0;
    man_ready = 1'b1;
    for (int k = 0; k < 50 && sb.size() > 0; k++) begin
      @(posedge clk);
      #1;
    end
    idle(1);
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
